// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute-stage ALU: op codes,
// controller/iterator state encodings and the multi-cycle op classifier.
package alu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD,  OP_ADDU, OP_SUB,  OP_SUBU,
        OP_AND,  OP_OR,   OP_XOR,  OP_NOR,
        OP_SLT,  OP_SLTU, OP_SLL,  OP_SRL,
        OP_SRA,  OP_SLLV, OP_SRLV, OP_SRAV,
        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
        OP_XORI, OP_LUI,  OP_SLTI, OP_SLTIU,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
        OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        IT_IDLE,
        IT_RUN,
        IT_FIX
    } iter_state_e;

    function automatic logic is_multicycle(input op_e op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide engine: one bit per cycle on operand magnitudes,
// followed by a sign-fix cycle in which done_o is high and hi_o/lo_o are valid.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         kill_i,
    input  logic         is_div_i,
    input  logic         is_signed_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    localparam int CW = $clog2(W);

    iter_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    a_q, a_d;
    logic            is_div_q, is_div_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            bzero_q, bzero_d;

    logic [W:0]      sum;
    logic [W:0]      shifted;
    logic [W:0]      diff;
    logic            neg_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IT_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            bzero_q  <= bzero_d;
        end
    end

    // prod_q is {accumulator, multiplier} for MUL and {remainder, dividend} for DIV.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        bzero_d  = bzero_q;
        sum      = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        shifted  = prod_q[2*W-1:W-1];
        diff     = shifted - {1'b0, opnd_q};

        case (state_q)
            IT_IDLE: begin
                if (start_i) begin
                    is_div_d = is_div_i;
                    neg_a_d  = is_signed_i & a_i[W-1];
                    neg_b_d  = is_signed_i & b_i[W-1];
                    bzero_d  = (b_i == '0);
                    a_d      = a_i;
                    opnd_d   = (is_signed_i & b_i[W-1]) ? -b_i : b_i;
                    prod_d   = {{W{1'b0}}, ((is_signed_i & a_i[W-1]) ? -a_i : a_i)};
                    cnt_d    = '0;
                    state_d  = IT_RUN;
                end
            end
            IT_RUN: begin
                if (is_div_q) begin
                    if (!diff[W]) prod_d = {diff[W-1:0], prod_q[W-2:0], 1'b1};
                    else          prod_d = {shifted[W-1:0], prod_q[W-2:0], 1'b0};
                end else begin
                    prod_d = {sum, prod_q[W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W-1)) state_d = IT_FIX;
            end
            IT_FIX:  state_d = IT_IDLE;
            default: state_d = IT_IDLE;
        endcase

        if (kill_i) state_d = IT_IDLE;
    end

    // Division by zero bypasses the sign fix so the caller sees all-ones / dividend.
    always_comb begin
        neg_res = neg_a_q ^ neg_b_q;
        if (is_div_q) begin
            if (bzero_q) begin
                lo_o = '1;
                hi_o = a_q;
            end else begin
                lo_o = neg_res ? -prod_q[W-1:0] : prod_q[W-1:0];
                hi_o = neg_a_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];
            end
        end else begin
            {hi_o, lo_o} = neg_res ? -prod_q : prod_q;
        end
    end

    assign busy_o = (state_q != IT_IDLE);
    assign done_o = (state_q == IT_FIX);

endmodule

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle EX-stage ALU: single-cycle logic/shift/arith ops plus iterative
// MULT/DIV with HI/LO registers, behind a valid/ready request/response pair.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(WORD_WIDTH),
    parameter int IMM_WIDTH   = 16,
    parameter int OP_WIDTH    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_WIDTH-1:0]    op,
    input  logic [WORD_WIDTH-1:0]  a,
    input  logic [WORD_WIDTH-1:0]  b,
    input  logic [IMM_WIDTH-1:0]   imm,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_WIDTH-1:0]  result,
    output logic                   zero,
    output logic [WORD_WIDTH-1:0]  hi,
    output logic [WORD_WIDTH-1:0]  lo,
    output logic [1:0]             dbg_state
);

    localparam int W = WORD_WIDTH;

    // Handshake: a request transfers on a cycle with in_valid && in_ready && !flush;
    // a response transfers on out_valid && out_ready. Only one op is ever in flight.

    state_e       state_q, state_d;
    logic [W-1:0] result_q, result_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic         zero_q, zero_d;

    op_e          op_s;
    logic [W-1:0] sext_imm, zext_imm, alu_res;
    logic         accept, is_div_op, is_signed_op;
    logic         iter_busy, iter_done;
    logic [W-1:0] iter_hi, iter_lo;

    assign op_s         = op_e'(op);
    assign sext_imm     = {{(W-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    assign zext_imm     = {{(W-IMM_WIDTH){1'b0}}, imm};
    assign in_ready     = (state_q == S_IDLE) && !iter_busy;
    assign accept       = in_valid && in_ready && !flush;
    assign is_div_op    = op_s inside {OP_DIV, OP_DIVU};
    assign is_signed_op = op_s inside {OP_MULT, OP_DIV};

    always_comb begin
        alu_res = '0;
        case (op_s)
            OP_ADD, OP_ADDU:   alu_res = a + b;
            OP_SUB, OP_SUBU:   alu_res = a - b;
            OP_AND:            alu_res = a & b;
            OP_OR:             alu_res = a | b;
            OP_XOR:            alu_res = a ^ b;
            OP_NOR:            alu_res = ~(a | b);
            OP_SLT:            alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:           alu_res = {{(W-1){1'b0}}, (a < b)};
            OP_SLL:            alu_res = b << shamt;
            OP_SRL:            alu_res = b >> shamt;
            OP_SRA:            alu_res = $signed(b) >>> shamt;
            OP_SLLV:           alu_res = b << a[SHAMT_WIDTH-1:0];
            OP_SRLV:           alu_res = b >> a[SHAMT_WIDTH-1:0];
            OP_SRAV:           alu_res = $signed(b) >>> a[SHAMT_WIDTH-1:0];
            OP_ADDI, OP_ADDIU: alu_res = a + sext_imm;
            OP_ANDI:           alu_res = a & zext_imm;
            OP_ORI:            alu_res = a | zext_imm;
            OP_XORI:           alu_res = a ^ zext_imm;
            OP_LUI:            alu_res = {imm, {(W-IMM_WIDTH){1'b0}}};
            OP_SLTI:           alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(sext_imm))};
            OP_SLTIU:          alu_res = {{(W-1){1'b0}}, (a < sext_imm)};
            OP_MFHI:           alu_res = hi_q;
            OP_MFLO:           alu_res = lo_q;
            OP_MTHI, OP_MTLO:  alu_res = a;
            default:           alu_res = '0;
        endcase
    end

    alu_muldiv_iter #(.W(W)) u_iter (
        .clk         (clk),
        .rst         (rst),
        .start_i     (accept && is_multicycle(op_s)),
        .kill_i      (flush),
        .is_div_i    (is_div_op),
        .is_signed_i (is_signed_op),
        .a_i         (a),
        .b_i         (b),
        .busy_o      (iter_busy),
        .done_o      (iter_done),
        .hi_o        (iter_hi),
        .lo_o        (iter_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // flush is checked ahead of the iterator's done and of out_ready.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_multicycle(op_s)) begin
                        state_d = is_div_op ? S_DIV : S_MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        if (op_s == OP_MTHI) hi_d = a;
                        if (op_s == OP_MTLO) lo_d = a;
                        state_d  = S_RESP;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (iter_done) begin
                    hi_d     = iter_hi;
                    lo_d     = iter_lo;
                    result_d = iter_lo;
                    zero_d   = (iter_lo == '0);
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_valid = (state_q == S_RESP);
    assign result    = result_q;
    assign zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv with a reference model driven from the
// observed request handshake and checked against the outputs every cycle.
module tb_alu_seq_muldiv;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [4:0]  op;
  logic [31:0] a, b, result, hi, lo;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic [1:0]  dbg_state;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_seq_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .imm       (imm),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(input op_e o, input logic [31:0] aa, input logic [31:0] bb,
                                 input logic [15:0] ii, input logic [4:0] sh,
                                 input logic [31:0] chi, input logic [31:0] clo);
    exp_t        e;
    logic [31:0] se, ze;
    logic [63:0] p;
    int          sa, sb;
    se = {{16{ii[15]}}, ii};
    ze = {16'h0, ii};
    sa = aa;
    sb = bb;
    e.hi = chi;
    e.lo = clo;
    e.res = 32'h0;
    e.lat = 1;
    e.acc = 0;
    e.seen = 0;
    case (o)
      OP_ADD, OP_ADDU:   e.res = aa + bb;
      OP_SUB, OP_SUBU:   e.res = aa - bb;
      OP_AND:            e.res = aa & bb;
      OP_OR:             e.res = aa | bb;
      OP_XOR:            e.res = aa ^ bb;
      OP_NOR:            e.res = ~(aa | bb);
      OP_SLT:            e.res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:           e.res = (aa < bb) ? 32'd1 : 32'd0;
      OP_SLL:            e.res = bb << sh;
      OP_SRL:            e.res = bb >> sh;
      OP_SRA:            e.res = sb >>> sh;
      OP_SLLV:           e.res = bb << aa[4:0];
      OP_SRLV:           e.res = bb >> aa[4:0];
      OP_SRAV:           e.res = sb >>> aa[4:0];
      OP_ADDI, OP_ADDIU: e.res = aa + se;
      OP_ANDI:           e.res = aa & ze;
      OP_ORI:            e.res = aa | ze;
      OP_XORI:           e.res = aa ^ ze;
      OP_LUI:            e.res = {ii, 16'h0};
      OP_SLTI:           e.res = (sa < int'(se)) ? 32'd1 : 32'd0;
      OP_SLTIU:          e.res = (aa < se) ? 32'd1 : 32'd0;
      OP_MFHI:           e.res = chi;
      OP_MFLO:           e.res = clo;
      OP_MTHI:           begin e.res = aa; e.hi = aa; end
      OP_MTLO:           begin e.res = aa; e.lo = aa; end
      OP_MULT, OP_MULTU: begin
        if (o == OP_MULT) p = longint'(sa) * longint'(sb);
        else              p = {32'h0, aa} * {32'h0, bb};
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.res = e.lo;
        e.lat = 34;
      end
      OP_DIV, OP_DIVU: begin
        if (bb == 32'h0) begin
          e.lo = 32'hffffffff;
          e.hi = aa;
        end else if (o == OP_DIV && aa == 32'h80000000 && bb == 32'hffffffff) begin
          e.lo = 32'h80000000;
          e.hi = 32'h0;
        end else if (o == OP_DIV) begin
          e.lo = sa / sb;
          e.hi = sa % sb;
        end else begin
          e.lo = aa / bb;
          e.hi = aa % bb;
        end
        e.res = e.lo;
        e.lat = 34;
      end
      default: e.res = 32'h0;
    endcase
    return e;
  endfunction

  // Handshake monitor: sampled at the active edge, before the DUT updates.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_hi = '0;
      m_lo = '0;
    end else if (flush) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        e = model(op_e'(op), a, b, imm, shamt, m_hi, m_lo);
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- scoreboard compare (every cycle, opposite edge) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_idle", in_ready, (exp_q.size() == 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          if (!exp_q[0].seen) begin
            check("latency", cyc - exp_q[0].acc + 1, exp_q[0].lat);
            exp_q[0].seen = 1;
            m_hi = exp_q[0].hi;
            m_lo = exp_q[0].lo;
          end
          check("result", result, exp_q[0].res);
          check("zero", zero, (exp_q[0].res == 32'h0));
        end
      end else if (exp_q.size() > 0 && exp_q[0].seen) begin
        check("out_valid_dropped", out_valid, 1'b1);
      end
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_req(input op_e o, input logic [31:0] aa, input logic [31:0] bb,
                           input logic [15:0] ii, input logic [4:0] sh);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    check("req_ready_timeout", in_ready, 1'b1);
    op = o; a = aa; b = bb; imm = ii; shamt = sh;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input op_e o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [15:0] ii, input logic [4:0] sh,
                        input logic [31:0] lit_res, input logic lit_zero, input int lit_lat);
    int t;
    drive_req(o, aa, bb, ii, sh);
    t = 1;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    check({name, "_lat"}, t, lit_lat);
    check({name, "_res"}, result, lit_res);
    check({name, "_zero"}, zero, lit_zero);
    if (out_ready) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; imm = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_zero", zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add",  OP_ADD,  32'h7fffffff, 32'h1, 16'h0, 5'd0, 32'h80000000, 1'b0, 1);
    run_op("sub",  OP_SUB,  32'h5, 32'h5, 16'h0, 5'd0, 32'h0, 1'b1, 1);
    run_op("slt",  OP_SLT,  32'hffffffff, 32'h1, 16'h0, 5'd0, 32'h1, 1'b0, 1);
    run_op("sltu", OP_SLTU, 32'hffffffff, 32'h1, 16'h0, 5'd0, 32'h0, 1'b1, 1);
    run_op("nor",  OP_NOR,  32'h0, 32'h0, 16'h0, 5'd0, 32'hffffffff, 1'b0, 1);
    run_op("srav", OP_SRAV, 32'h8, 32'h80000000, 16'h0, 5'd0, 32'hff800000, 1'b0, 1);
    run_op("sllv", OP_SLLV, 32'h24, 32'h1, 16'h0, 5'd0, 32'h10, 1'b0, 1);
    run_op("srl",  OP_SRL,  32'h0, 32'h80000000, 16'h0, 5'd31, 32'h1, 1'b0, 1);
    run_op("addi", OP_ADDI, 32'h5, 32'h0, 16'hfffe, 5'd0, 32'h3, 1'b0, 1);
    run_op("andi", OP_ANDI, 32'hffffffff, 32'h0, 16'h8000, 5'd0, 32'h8000, 1'b0, 1);
    run_op("xori", OP_XORI, 32'hf0, 32'h0, 16'h00ff, 5'd0, 32'h0f, 1'b0, 1);

    run_op("mult", OP_MULT, 32'hfffffffe, 32'h3, 16'h0, 5'd0, 32'hfffffffa, 1'b0, 34);
    check("mult_hi", hi, 32'hffffffff);
    check("mult_lo", lo, 32'hfffffffa);
    run_op("multu", OP_MULTU, 32'hfffffffe, 32'h3, 16'h0, 5'd0, 32'hfffffffa, 1'b0, 34);
    check("multu_hi", hi, 32'h2);
    check("multu_lo", lo, 32'hfffffffa);
    run_op("mult_nn", OP_MULT, 32'hfffffffb, 32'hfffffffb, 16'h0, 5'd0, 32'd25, 1'b0, 34);
    check("mult_nn_hi", hi, 32'h0);

    run_op("div", OP_DIV, 32'hfffffff9, 32'h2, 16'h0, 5'd0, 32'hfffffffd, 1'b0, 34);
    check("div_hi", hi, 32'hffffffff);
    run_op("div_pn", OP_DIV, 32'h7, 32'hfffffffe, 16'h0, 5'd0, 32'hfffffffd, 1'b0, 34);
    check("div_pn_hi", hi, 32'h1);
    run_op("divu0", OP_DIVU, 32'h10, 32'h0, 16'h0, 5'd0, 32'hffffffff, 1'b0, 34);
    check("divu0_hi", hi, 32'h10);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hffffffff, 16'h0, 5'd0, 32'h80000000, 1'b0, 34);
    check("div_ovf_hi", hi, 32'h0);
    check("div_ovf_lo", lo, 32'h80000000);

    // Backpressure: response must hold while out_ready is low.
    out_ready = 1'b0;
    run_op("sra", OP_SRA, 32'h0, 32'h80000000, 16'h0, 5'd4, 32'hf8000000, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", result, 32'hf8000000);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released", out_valid, 1'b0);

    // flush during DIV: hi/lo keep the last committed values.
    drive_req(OP_DIV, 32'd100, 32'd7, 16'h0, 5'd0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_div_valid", out_valid, 1'b0);
    check("flush_div_ready", in_ready, 1'b1);
    check("flush_div_hi", hi, 32'h0);
    check("flush_div_lo", lo, 32'h80000000);
    repeat (40) @(negedge clk);
    check("flush_div_never_valid", out_valid, 1'b0);

    // flush in IDLE ignores the same-cycle request.
    op = OP_ADD; a = 32'h1; b = 32'h1; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_valid", out_valid, 1'b0);
    check("flush_idle_ready", in_ready, 1'b1);

    // flush in RESP drops the result.
    out_ready = 1'b0;
    run_op("ori", OP_ORI, 32'h00010000, 32'h0, 16'h1234, 5'd0, 32'h00011234, 1'b0, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    check("flush_resp_valid", out_valid, 1'b0);

    // Moves and immediates.
    run_op("mthi", OP_MTHI, 32'h1234, 32'h0, 16'h0, 5'd0, 32'h1234, 1'b0, 1);
    run_op("mfhi", OP_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 32'h1234, 1'b0, 1);
    run_op("mtlo", OP_MTLO, 32'h55, 32'h0, 16'h0, 5'd0, 32'h55, 1'b0, 1);
    run_op("mflo", OP_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 32'h55, 1'b0, 1);
    run_op("sltiu", OP_SLTIU, 32'h1, 32'h0, 16'hffff, 5'd0, 32'h1, 1'b0, 1);
    run_op("lui", OP_LUI, 32'h0, 32'h0, 16'habcd, 5'd0, 32'habcd0000, 1'b0, 1);

    // Reset in the middle of MULT.
    drive_req(OP_MULT, 32'h1234, 32'h5678, 16'h0, 5'd0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mult_in_ready", in_ready, 1'b1);
    check("rst_mult_out_valid", out_valid, 1'b0);
    check("rst_mult_result", result, 32'h0);
    check("rst_mult_zero", zero, 1'b0);
    check("rst_mult_hi", hi, 32'h0);
    check("rst_mult_lo", lo, 32'h0);
    repeat (40) @(negedge clk);
    check("rst_mult_never_valid", out_valid, 1'b0);

    run_op("post_rst_add", OP_ADDU, 32'hffffffff, 32'h2, 16'h0, 5'd0, 32'h1, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
